// File: rtl/bridge_fifo_slave.sv
// Bridge-mapped slave with an RX FIFO (host to core) and a TX FIFO (core to host),
// plus a STATUS register with sticky error flags and a CONTROL flush bit.
module bridge_fifo_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h8100_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFF0,
  parameter int          DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bridge_addr,
  input  logic [31:0] bridge_wr_data,
  input  logic        bridge_wr,
  input  logic        bridge_rd,
  output logic [31:0] bridge_rd_data,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   rx_mem [DEPTH];
  logic [31:0]   tx_mem [DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0] rx_count, tx_count;
  logic          rx_overflow, tx_underflow;

  logic        hit, wr_hit, rd_any, rd_hit, data_wr, data_rd;
  logic [1:0]  offset;
  logic        flush, clear_sticky;
  logic        rx_full, rx_empty, tx_full, tx_empty;
  logic        rx_push, rx_pop, tx_push, tx_pop;
  logic [31:0] status, rd_value;

  assign hit          = (bridge_addr & ADDR_MASK) == BASE_ADDR;
  assign offset       = bridge_addr[3:2];
  assign wr_hit       = bridge_wr && hit;
  assign rd_any       = bridge_rd && !bridge_wr;
  assign rd_hit       = rd_any && hit;
  assign data_wr      = wr_hit && (offset == 2'd0);
  assign data_rd      = rd_hit && (offset == 2'd0);
  assign clear_sticky = wr_hit && (offset == 2'd1) && bridge_wr_data[0];
  assign flush        = wr_hit && (offset == 2'd2) && bridge_wr_data[0];

  assign rx_full  = rx_count == FULL_CNT;
  assign rx_empty = rx_count == '0;
  assign tx_full  = tx_count == FULL_CNT;
  assign tx_empty = tx_count == '0;

  // Full/empty come from registered counts, so a same-cycle pop never frees room for a push.
  assign rx_push = data_wr && !rx_full;
  assign rx_pop  = rx_ready && !rx_empty;
  assign tx_push = tx_valid && !tx_full;
  assign tx_pop  = data_rd && !tx_empty;

  assign rx_data  = rx_mem[rx_rd_ptr];
  assign rx_valid = !rx_empty;
  assign tx_ready = !tx_full;

  assign status = {6'b0, tx_underflow, rx_overflow, 6'b0, rx_full, tx_empty,
                   8'(rx_count), 8'(tx_count)};

  always_comb begin
    rd_value = 32'h0;
    if (hit) begin
      case (offset)
        2'd0:    rd_value = tx_empty ? 32'h0 : tx_mem[tx_rd_ptr];
        2'd1:    rd_value = status;
        default: rd_value = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= bridge_wr_data;
      if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr      <= '0;
      rx_rd_ptr      <= '0;
      rx_count       <= '0;
      tx_wr_ptr      <= '0;
      tx_rd_ptr      <= '0;
      tx_count       <= '0;
      rx_overflow    <= 1'b0;
      tx_underflow   <= 1'b0;
      bridge_rd_data <= 32'h0;
    end else begin
      if (rd_any) bridge_rd_data <= rd_value;

      // A sticky clear and a fresh error in the same cycle cannot occur: a write blocks the read.
      if (clear_sticky) begin
        rx_overflow  <= 1'b0;
        tx_underflow <= 1'b0;
      end else begin
        if (data_wr && rx_full)  rx_overflow  <= 1'b1;
        if (data_rd && tx_empty) tx_underflow <= 1'b1;
      end

      if (flush) begin
        rx_wr_ptr <= '0;
        rx_rd_ptr <= '0;
        rx_count  <= '0;
        tx_wr_ptr <= '0;
        tx_rd_ptr <= '0;
        tx_count  <= '0;
      end else begin
        if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
        if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
        if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
        else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);

        if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
        if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
        if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
        else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);
      end
    end
  end

endmodule

// File: doc/bridge_fifo_slave.md
BRIDGE_FIFO_SLAVE -- requirements
Module: bridge_fifo_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8100_0000, the window base address.
REQ-002 SHALL have parameter ADDR_MASK, default 32'hFFFF_FFF0, the window match mask.
REQ-003 SHALL have parameter DEPTH, default 16, the entries per FIFO; legal values are powers of 2 from 2 to 128.
REQ-004 SHALL have ports:
- clk  in  1  clock; one clock domain only.
- reset  in  1  reset; synchronous, active-high.
- bridge_addr  in  32  bridge address.
- bridge_wr_data  in  32  bridge write data.
- bridge_wr  in  1  write strobe; one cycle per access.
- bridge_rd  in  1  read strobe; one cycle per access.
- bridge_rd_data  out  32  registered read data.
- rx_data  out  32  host-to-core FIFO head.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  core pops RX when rx_valid is also high.
- tx_data  in  32  core-to-host data.
- tx_valid  in  1  core push request.
- tx_ready  out  1  TX FIFO not full.

Function
REQ-005 SHALL select the window when (bridge_addr & ADDR_MASK) == BASE_ADDR. Register offset is bridge_addr[3:2].
REQ-006 Offset 0, DATA: a write SHALL push bridge_wr_data into RX; a read SHALL pop the TX head into bridge_rd_data.
REQ-007 Offset 1, STATUS, read value SHALL be:
- [7:0] tx_count
- [15:8] rx_count
- bit16 tx_empty
- bit17 rx_full
- bit24 rx_overflow (sticky)
- bit25 tx_underflow (sticky)
- all other bits 0.
REQ-008 A STATUS write with wr_data[0]=1 SHALL clear both sticky flags.
REQ-009 Offset 2, CONTROL: a write with wr_data[0]=1 SHALL flush both FIFOs (counts 0, pointers 0) on the next edge. A CONTROL read SHALL return 0.
REQ-010 Offset 3 and out-of-window reads SHALL return 0; writes there SHALL have no effect.
REQ-011 Read latency SHALL be exactly 1 cycle: bridge_rd_data updates on the edge after bridge_rd and holds until the next in-window or out-of-window read.
REQ-012 If bridge_wr and bridge_rd are high together, the write SHALL be performed and the read ignored.
REQ-013 A DATA write while RX is full SHALL be dropped and SHALL set rx_overflow. Fullness is judged on the pre-edge count, even if the core pops in the same cycle.
REQ-014 A DATA read while TX is empty SHALL return 32'h0000_0000 and SHALL set tx_underflow. A core push in the same cycle is not visible to that read.
REQ-015 Each FIFO SHALL support a simultaneous push and pop when neither full nor empty; the count is then unchanged.
REQ-016 tx_ready SHALL be !tx_full, registered-state based; tx_valid while !tx_ready SHALL be ignored.
REQ-017 rx_data SHALL show the RX head combinationally from FIFO storage. rx_valid SHALL equal (rx_count != 0).
REQ-018 A flush SHALL override any push or pop in the same cycle and SHALL not alter the sticky flags.
REQ-019 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH. Counts SHALL be log2(DEPTH)+1 bits, zero-extended into 8-bit STATUS fields.

Reset
REQ-020 While reset is high at an edge, the block SHALL set:
- FIFO counts and pointers to 0
- sticky flags to 0
- bridge_rd_data to 0
- resulting rx_valid=0 and tx_ready=1.
REQ-021 Reset mid-operation SHALL discard FIFO contents. Bridge strobes coincident with reset SHALL be ignored.

Verification
REQ-022 Bridge writes 0x11, 0x22, 0x33 to DATA, core rx_ready=1 -> rx_data 0x11, 0x22, 0x33 in order; rx_valid low afterwards; STATUS[15:8]=0.
REQ-023 Core pushes 0xA5A5_0001; bridge reads DATA -> bridge_rd_data=0xA5A5_0001 exactly 1 cycle after bridge_rd; a second read returns 0 and STATUS bit25=1.
REQ-024 17 DATA writes with DEPTH=16, rx_ready=0 -> rx_full=1, rx_overflow=1, first 16 values retained. STATUS write of 1 clears bit24.
REQ-025 Core pushes 16 words -> tx_ready=0. Bridge read plus core push in the same cycle -> push ignored, tx_count=15. Wrap test: 40 push/pop pairs with data intact.
REQ-026 CONTROL write 1 with both FIFOs holding 3 entries and a simultaneous DATA push -> both counts 0 next cycle, sticky flags unchanged.
